// File: rtl/serial_to_parallel.sv
//------------------------------------------------------------------------------
// serial_to_parallel
//
// Receive side of the LSB-first serial link. Serial bits qualified by
// bit_valid are collected into a WIDTH-bit word. A frame begins with a bit
// that has frame_start set. Each finished word goes into a one-entry
// holding register, which is drained by a valid/ready consumer.
//
// Optional feature (macro SERIAL_TO_PARALLEL_PARITY_EN):
//   After data bit WIDTH-1, one extra even-parity bit is received. The
//   result of the parity check is presented on parity_err, next to out_data.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset
//   serial_in    serial data bit, sampled only when bit_valid=1
//   bit_valid    qualifies serial_in for one clock
//   frame_start  with bit_valid, marks the current bit as bit 0 of a word
//   out_data     assembled word; bit 0 is the first bit received
//   out_valid    out_data holds an unconsumed word
//   out_ready    consumer accepts the word when out_valid=1
//   overflow     one-cycle pulse: a completed word was dropped (holding full)
//   frame_err    one-cycle pulse: partial word aborted by a new frame_start
//   parity_err   (parity build only) parity check result for out_data
//------------------------------------------------------------------------------
module serial_to_parallel #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             serial_in,
   input  logic             bit_valid,
   input  logic             frame_start,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             overflow,
   output logic             frame_err
`ifdef SERIAL_TO_PARALLEL_PARITY_EN
   ,
   output logic             parity_err
`endif
);

   localparam int             CW   = $clog2(WIDTH);
   localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SHIFT  = 2'd1,
      S_PARITY = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_next;
   logic [CW-1:0]    r_count;
   logic [WIDTH-1:0] r_shift;

   // Control strobes from the FSM
   logic             w_start;     // the current bit becomes bit 0 of a new word
   logic             w_capture;   // the current bit goes into position r_count
   logic             w_abort;     // a partial word is discarded by frame_start
   logic             w_complete;  // a full word is ready this cycle
   logic [WIDTH-1:0] w_word;      // the completed word, including this cycle's bit
   logic             w_load;      // the holding register accepts w_word
`ifdef SERIAL_TO_PARALLEL_PARITY_EN
   logic             w_perr;
`endif

   //---------------------------------------------------------------------------
   // State register
   //---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   //---------------------------------------------------------------------------
   // Next-state and control decode
   //---------------------------------------------------------------------------
   always_comb begin
      w_next     = r_state;
      w_start    = 1'b0;
      w_capture  = 1'b0;
      w_abort    = 1'b0;
      w_complete = 1'b0;
      w_word     = r_shift;
`ifdef SERIAL_TO_PARALLEL_PARITY_EN
      w_perr     = 1'b0;
`endif
      case (r_state)
         S_IDLE: begin
            // Bits without frame_start are ignored between frames.
            if (bit_valid && frame_start) begin
               w_start = 1'b1;
               w_next  = S_SHIFT;
            end
         end
         S_SHIFT: begin
            if (bit_valid) begin
               if (frame_start) begin
                  w_abort = 1'b1;
                  w_start = 1'b1;
               end else begin
                  w_capture = 1'b1;
                  if (r_count == LAST) begin
`ifdef SERIAL_TO_PARALLEL_PARITY_EN
                     w_next = S_PARITY;
`else
                     // The last bit bypasses r_shift, so the word is
                     // visible one cycle after its final bit.
                     w_complete         = 1'b1;
                     w_word[WIDTH-1]    = serial_in;
                     w_next             = S_IDLE;
`endif
                  end
               end
            end
         end
`ifdef SERIAL_TO_PARALLEL_PARITY_EN
         S_PARITY: begin
            if (bit_valid) begin
               if (frame_start) begin
                  w_abort = 1'b1;
                  w_start = 1'b1;
                  w_next  = S_SHIFT;
               end else begin
                  // Even parity: data bits XOR parity bit must be zero.
                  w_complete = 1'b1;
                  w_perr     = (^r_shift) ^ serial_in;
                  w_next     = S_IDLE;
               end
            end
         end
`endif
         default: w_next = S_IDLE;
      endcase
   end

   // A pop in the same cycle frees the slot for the incoming word.
   assign w_load = w_complete && (!out_valid || out_ready);

   //---------------------------------------------------------------------------
   // Bit assembly. Bits are written in place by index. Positions that have
   // not yet been written in this frame keep stale values, which is harmless
   // because every position is rewritten before the word completes.
   //---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_shift <= '0;
         r_count <= '0;
      end else if (w_start) begin
         r_shift[0] <= serial_in;
         r_count    <= CW'(1);
      end else if (w_capture) begin
         r_shift[r_count] <= serial_in;
         r_count          <= (r_count == LAST) ? '0 : r_count + CW'(1);
      end
   end

   //---------------------------------------------------------------------------
   // Holding register and status pulses
   //---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_data   <= '0;
         out_valid  <= 1'b0;
         overflow   <= 1'b0;
         frame_err  <= 1'b0;
`ifdef SERIAL_TO_PARALLEL_PARITY_EN
         parity_err <= 1'b0;
`endif
      end else begin
         overflow  <= w_complete && !w_load;
         frame_err <= w_abort;
         if (w_load) begin
            out_data   <= w_word;
            out_valid  <= 1'b1;
`ifdef SERIAL_TO_PARALLEL_PARITY_EN
            parity_err <= w_perr;
`endif
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: doc/serial_to_parallel.md
Name: serial_to_parallel

Overview:
- Receive side of the LSB-first serial link driven by the team's parallel-to-serial shifter.
- Collects WIDTH serial bits, framed by a start marker, into a parallel word.
- Presents each completed word on a valid/ready output port backed by a one-entry holding register.
- Sits between the serial link pins and the downstream word consumer.

Parameters:
- WIDTH, 8, data word width in bits (legal range 2..32).

Ports:
- clk  input  1  rising-edge clock; all logic in this single domain.
- rst_n  input  1  reset, synchronous, active-low.
- serial_in  input  1  serial data bit, sampled only when bit_valid=1.
- bit_valid  input  1  qualifies serial_in for one clock.
- frame_start  input  1  with bit_valid=1, marks the current bit as bit 0 of a word; ignored when bit_valid=0.
- out_data  output  WIDTH  assembled word; bit 0 is the first bit received.
- out_valid  output  1  out_data holds an unconsumed word.
- out_ready  input  1  consumer accepts the word when out_valid=1 and out_ready=1.
- overflow  output  1  one-cycle pulse: a completed word was dropped because the holding register was full.
- frame_err  output  1  one-cycle pulse: a frame_start arrived mid-word and the partial word was discarded.

Behaviour:
- Reset (rst_n=0 at a clk edge): state IDLE; bit counter, shift register and out_data cleared to 0; out_valid=0; overflow=0; frame_err=0. Reset wins over every other event in the same cycle and discards any partial word.
- State IDLE:
  - bit_valid=1 and frame_start=1: capture serial_in into bit 0, set count=1, go to SHIFT.
  - bit_valid=1 with frame_start=0: ignore the bit and stay in IDLE.
- State SHIFT:
  - bit_valid=1 and frame_start=0: write serial_in into bit position count, then count+1.
  - When the bit at position WIDTH-1 is captured, the word is complete: go to IDLE, count=0.
  - bit_valid=0: hold state, count and shift register.
  - bit_valid=1 and frame_start=1: pulse frame_err for one cycle, discard the partial word, capture this bit as bit 0, count=1, stay in SHIFT.
- Bit placement: bits are written in place by index, not shifted. Bits not yet written in the current frame are don't-care internally.
- Word completion and latency:
  - out_valid rises and out_data updates on the clock edge that captures bit WIDTH-1, so they are visible the following cycle.
  - Bit-to-word latency is 1 cycle.
- Holding register:
  - A completed word loads if out_valid=0, or if out_valid=1 and out_ready=1 in the same cycle (simultaneous pop and push keeps out_valid=1 with the new data).
  - Otherwise the new word is dropped, out_data and out_valid are unchanged, and overflow pulses for one cycle.
- Handshake:
  - out_valid=1 and out_ready=1 with no completion in that cycle: out_valid clears on the next edge.
  - out_data is stable while out_valid=1 and out_ready=0.
  - out_ready is ignored while out_valid=0.
- Back-to-back frames: a frame_start with bit_valid in the cycle right after completion starts a new word with no gap required.

Optional Feature:
- Macro: SERIAL_TO_PARALLEL_PARITY_EN.
- Defined:
  - One extra even-parity bit follows bit WIDTH-1 before the word completes; SHIFT moves to an additional PARITY state.
  - In PARITY, the next bit_valid bit is compared against the XOR of the data bits; the word then completes with the same holding and overflow rules.
  - Added output parity_err (1 bit) is registered alongside out_data and valid while out_valid=1; it is 0 at reset.
  - frame_start during PARITY follows the same abort and frame_err rule as in SHIFT.
- Undefined: no PARITY state, no parity_err port; behaviour exactly as above.

Test Plan:
- Reset, then WIDTH=8, bits 1,0,1,0,0,1,0,1 with frame_start on the first -> out_valid=1 with out_data=0xA5 the cycle after the 8th bit; overflow=0; frame_err=0.
- Same frame with bit_valid low for 3 cycles between bits 4 and 5 -> out_data=0xA5; no extra bits captured during the gaps.
- 0x3C received, out_ready held 0, then 0xFF received -> overflow pulses one cycle; out_data stays 0x3C; after out_ready=1, out_valid drops next cycle.
- Four bits of a frame, then a new frame_start followed by 0x81 -> frame_err pulses once; out_data=0x81.
- Word 0x12 pending with out_ready=1 in the exact cycle 0x34 completes -> out_valid stays 1 and out_data=0x34; no overflow.
- rst_n=0 after 5 bits, then a full 0x5A frame -> no word is output for the partial frame; out_data=0x5A. With PARITY_EN, a wrong parity bit on 0x5A gives parity_err=1.
